// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the fetch-queue entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Fetch-queue storage: in-order reserve, fill and pop pointers over DEPTH entries.
// head_valid is registered: an entry filled in cycle N is visible at the head in cycle N+1.
module fq_ring
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   rsv,
  input  word_t                  rsv_pc,
  input  logic                   fill,
  input  word_t                  fill_instr,
  input  logic                   pop,
  output word_t                  head_pc,
  output word_t                  head_instr,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] used,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  fq_entry_t         mem [DEPTH];
  logic [DEPTH-1:0]  filled, filled_nxt;
  logic [AW:0]       rsv_ptr, fill_ptr, pop_ptr;
  logic [AW:0]       rsv_nxt, fill_nxt, pop_nxt;
  logic              head_valid_nxt;

  always_comb begin
    filled_nxt = filled;
    rsv_nxt    = rsv_ptr;
    fill_nxt   = fill_ptr;
    pop_nxt    = pop_ptr;
    if (flush) begin
      filled_nxt = '0;
      rsv_nxt    = '0;
      fill_nxt   = '0;
      pop_nxt    = '0;
    end else begin
      if (rsv) begin
        filled_nxt[rsv_ptr[AW-1:0]] = 1'b0;
        rsv_nxt = rsv_ptr + PTR_ONE;
      end
      if (fill) begin
        filled_nxt[fill_ptr[AW-1:0]] = 1'b1;
        fill_nxt = fill_ptr + PTR_ONE;
      end
      if (pop) begin
        pop_nxt = pop_ptr + PTR_ONE;
      end
    end
    // A popped slot keeps its filled bit until re-reserved, so occupancy qualifies it.
    head_valid_nxt = filled_nxt[pop_nxt[AW-1:0]] && (rsv_nxt != pop_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filled     <= '0;
      rsv_ptr    <= '0;
      fill_ptr   <= '0;
      pop_ptr    <= '0;
      head_valid <= 1'b0;
    end else begin
      filled     <= filled_nxt;
      rsv_ptr    <= rsv_nxt;
      fill_ptr   <= fill_nxt;
      pop_ptr    <= pop_nxt;
      head_valid <= head_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rsv && !flush) begin
      mem[rsv_ptr[AW-1:0]].pc <= rsv_pc;
    end
    if (fill && !flush) begin
      mem[fill_ptr[AW-1:0]].instr <= fill_instr;
    end
  end

  assign head_pc    = mem[pop_ptr[AW-1:0]].pc;
  assign head_instr = mem[pop_ptr[AW-1:0]].instr;
  assign used       = rsv_ptr - pop_ptr;
  assign pending    = rsv_ptr - fill_ptr;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses for decode,
// and on redirect flushes the queue while discarding responses still owed to dropped requests.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  word_t          fetch_pc;
  word_t          head_pc, head_instr;
  logic [CW-1:0]  drop_cnt, drop_nxt, used, pending;
  logic [CW:0]    occupancy, drop_sum;
  logic           accept, fill, pop, head_valid, rsp_consumed;

  assign occupancy      = {1'b0, used} + {1'b0, drop_cnt};
  assign imem_req_valid = rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign out_valid = head_valid && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? head_pc : '0;
  assign out_instr = out_valid ? head_instr : '0;

  assign fill = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (pending != '0);

  // Outstanding responses after a redirect: older drops plus pending entries, less any
  // response consumed in the redirect cycle itself.
  assign rsp_consumed = imem_rsp_valid && ((drop_cnt != '0) || (pending != '0));
  assign drop_sum     = {1'b0, drop_cnt} + {1'b0, pending} - (CW+1)'(rsp_consumed);

  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      drop_nxt = (drop_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : drop_sum[CW-1:0];
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_nxt = drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .rsv        (accept),
    .rsv_pc     (fetch_pc),
    .fill       (fill),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .head_valid (head_valid),
    .used       (used),
    .pending    (pending)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order instruction memory model (data = addr + MAGIC).
module tb_instr_fetch_queue;

  localparam logic [31:0] MAGIC = 32'h1000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        mem_hold = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] mq[$];

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Memory: records accepted addresses mid-cycle, answers one cycle later in order.
  always @(negedge clk) begin
    if (!rst_n) mq.delete();
    else if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
  end

  always @(posedge clk) begin
    #2;
    if (rst_n && !mem_hold && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq.pop_front() + MAGIC;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic do_reset(input logic rdy, input logic ordy, input logic hold);
    @(posedge clk); #1;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = rdy; out_ready = ordy; mem_hold = hold;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    rst_n = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1; mem_hold = 1'b0;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      bad++; $display("FAIL first_req got valid=%b addr=%h exp valid=1 addr=0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream;
    logic [31:0] epc;
    do_reset(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        bad++; $display("FAIL stream_req k=%0d got valid=%b addr=%h exp addr=%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
      end
      total++; if (out_valid !== (k >= 2)) begin
        bad++; $display("FAIL stream_out_valid k=%0d got=%b exp=%b", k, out_valid, (k >= 2));
      end
      if (k >= 2) begin
        epc = 32'(4 * (k - 2));
        total++; if (out_pc !== epc || out_instr !== epc + MAGIC) begin
          bad++; $display("FAIL stream_out k=%0d got pc=%h instr=%h exp pc=%h instr=%h", k, out_pc, out_instr, epc, epc + MAGIC);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    int n = 0;
    logic [31:0] epc;
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) acc++;
      @(posedge clk); #1;
    end
    total++; if (acc != 4) begin bad++; $display("FAIL bp_accepts got=%0d exp=4", acc); end
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      bad++; $display("FAIL bp_full got req_valid=%b out_valid=%b pc=%h exp 0 1 0", imem_req_valid, out_valid, out_pc);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && n < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        epc = 32'(4 * n);
        total++; if (out_pc !== epc || out_instr !== epc + MAGIC) begin
          bad++; $display("FAIL bp_drain n=%0d got pc=%h instr=%h exp pc=%h instr=%h", n, out_pc, out_instr, epc, epc + MAGIC);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    total++; if (n != 6) begin bad++; $display("FAIL bp_drain_timeout got=%0d exp=6", n); end
  endtask

  task automatic test_redirect;
    int n = 0;
    logic [31:0] epc;
    do_reset(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; mem_hold = 1'b0;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL redir_cycle got req_valid=%b out_valid=%b exp 0 0", imem_req_valid, out_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      bad++; $display("FAIL redir_addr got valid=%b addr=%h exp 1 100", imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 20 && n < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        epc = 32'h100 + 32'(4 * n);
        total++; if (out_pc !== epc || out_instr !== epc + MAGIC) begin
          bad++; $display("FAIL redir_out n=%0d got pc=%h instr=%h exp pc=%h instr=%h", n, out_pc, out_instr, epc, epc + MAGIC);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    total++; if (n != 2) begin bad++; $display("FAIL redir_timeout got=%0d exp=2", n); end
  endtask

  task automatic test_stall;
    do_reset(1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
        bad++; $display("FAIL stall_addr k=%0d got valid=%b addr=%h exp 1 8", k, imem_req_valid, imem_req_addr);
      end
      @(posedge clk); #1;
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (imem_req_addr !== 32'h8) begin bad++; $display("FAIL stall_release got=%h exp=8", imem_req_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (imem_req_addr !== 32'hC) begin bad++; $display("FAIL stall_next got=%h exp=c", imem_req_addr); end
  endtask

  task automatic test_wrap;
    logic [31:0] epc = 32'hFFFF_FFFC;
    logic        seen = 1'b0;
    do_reset(1'b0, 1'b1, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL wrap_redir_valid got=%b exp=0", imem_req_valid); end
    @(posedge clk); #1;
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_top got valid=%b addr=%h exp 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", imem_req_addr); end
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        total++; if (out_pc !== epc || out_instr !== epc + MAGIC) begin
          bad++; $display("FAIL wrap_out got pc=%h instr=%h exp pc=%h instr=%h", out_pc, out_instr, epc, epc + MAGIC);
        end
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL wrap_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset_abort;
    logic seen = 1'b0;
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL abort_full got out_valid=%b req_valid=%b exp 1 0", out_valid, imem_req_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL abort_async got out_valid=%b req_valid=%b exp 0 0", out_valid, imem_req_valid);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_restart got req_valid=%b addr=%h out_valid=%b exp 1 0 0", imem_req_valid, imem_req_addr, out_valid);
    end
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        total++; if (out_pc !== 32'h0 || out_instr !== MAGIC) begin
          bad++; $display("FAIL abort_out got pc=%h instr=%h exp pc=0 instr=%h", out_pc, out_instr, MAGIC);
        end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL abort_timeout got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_stall();
    test_wrap();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: redirect_valid  input  1  flush and restart fetch (branch/jump target from PC_Next logic).
REQ-006 SHALL have port: redirect_pc  input  32  new fetch address.
REQ-007 SHALL have port: imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port: imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port: imem_req_addr  output  32  fetch address.
REQ-010 SHALL have port: imem_rsp_valid  input  1  instruction word returning, in request order, no backpressure.
REQ-011 SHALL have port: imem_rsp_data  input  32  instruction word.
REQ-012 SHALL have port: out_valid  output  1  head instruction available to decode.
REQ-013 SHALL have port: out_ready  input  1  decode accepts head.
REQ-014 SHALL have port: out_instr  output  32  head instruction.
REQ-015 SHALL have port: out_pc  output  32  address of head instruction.

Function
REQ-016 SHALL hold fetch_pc; request accepted (imem_req_valid && imem_req_ready) -> fetch_pc += 4, wrapping modulo 2^32.
REQ-017 SHALL reserve one queue entry per accepted request, recording its address; entry marked pending until filled.
REQ-018 SHALL assert imem_req_valid only when (entries used + drop_cnt) < DEPTH and redirect_valid is low.
REQ-019 SHALL keep imem_req_addr stable while imem_req_valid is high and not yet accepted, except on redirect.
REQ-020 SHALL fill the oldest pending entry with imem_rsp_data on each non-discarded response.
REQ-021 SHALL drive out_valid from a registered flag: a response filling the head entry in cycle N gives out_valid in cycle N+1.
REQ-022 SHALL pop the head entry on out_valid && out_ready; out_pc/out_instr come from the head entry.
REQ-023 SHALL support request accept, response fill and pop in the same cycle without loss or duplication.
REQ-024 SHALL, on redirect_valid: drop all entries, set drop_cnt to the number of in-flight (pending) requests, load fetch_pc with redirect_pc and bits[1:0] forced to 0.
REQ-025 SHALL force imem_req_valid and out_valid low in the redirect cycle and ignore any out_ready handshake that cycle.
REQ-026 SHALL treat a response arriving in the redirect cycle as stale, and discard the next drop_cnt responses after it, decrementing per discard.
REQ-027 SHALL allow redirect with drop_cnt nonzero (accumulates); drop_cnt saturates at DEPTH and never underflows.
REQ-028 SHALL not require a response in the same cycle as request acceptance; minimum memory latency is one cycle.

Reset
REQ-029 SHALL, while rst is low, clear all entries, drop_cnt=0, fetch_pc=RESET_PC, imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0.
REQ-030 SHALL issue the first request (addr RESET_PC) in the first cycle after rst deasserts.
REQ-031 SHALL treat reset mid-operation as a full abort; responses arriving after release belong to the fresh stream (memory is reset together).

Structure
REQ-032 SHALL take XLEN=32, RESET_PC default and NOP encoding 32'h0000_0013 from shared package riscv_pkg.
REQ-033 SHALL place storage in sub-module fq_ring (reserve, fill and pop pointers, DEPTH entries of {pc, instr, filled}).

Verification
REQ-034 SHALL cover: reset release, imem_req_ready=1, 1-cycle memory -> requests 0x0,0x4,0x8,...; out_pc 0x0 with matching instr at 2 cycles after first accept.
REQ-035 SHALL cover: out_ready=0 throughout -> exactly 4 requests accepted, imem_req_valid low afterward, no data lost when out_ready rises.
REQ-036 SHALL cover: redirect_pc=0x103 with 3 requests in flight -> next request addr 0x100, 3 stale responses discarded, first out_pc=0x100.
REQ-037 SHALL cover: imem_req_ready held low 5 cycles -> imem_req_addr constant at 0x8 throughout.
REQ-038 SHALL cover: fetch_pc=0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
REQ-039 SHALL cover: rst asserted with full queue -> out_valid and imem_req_valid low immediately (asynchronous); restart at RESET_PC.
